mem_bus_arbiter: RTL and testbench

//  Shares the single-port MEM (EN/R_W/MFC handshake) between the fetch unit (port F) and the

---
 rtl/mem_bus_pkg.sv | 27 ++
 rtl/mfc_sync.sv | 32 +++
 rtl/mem_bus_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the MEM bus arbiter: FSM states, requester ids,
// MEM R_W encoding and the two-requester alternation rule.
package mem_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        RELEASE,
        DONE
    } state_e;

    localparam logic GNT_F     = 1'b0;
    localparam logic GNT_D     = 1'b1;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    // A lone requester wins outright; on a tie the one not served last wins.
    function automatic logic arb_pick(input logic f_req, input logic d_req, input logic last);
        if (f_req && d_req) begin
            return ~last;
        end
        return d_req ? GNT_D : GNT_F;
    endfunction

endpackage

// File: rtl/mfc_sync.sv
// Two-flop synchroniser for MEM status inputs (and the reset release); clears to 0
// asynchronously so a cleared output never depends on the input during reset.
module mfc_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port MEM between fetch (F) and load/store (D): alternating arbitration,
// registered EN sequencing with a synchronised MFC, per-request ack and timeout error.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_ack,
    output logic              f_err,
    input  logic              d_req,
    input  logic              d_rw,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rw,
    output logic              mem_en,
    input  logic              mem_mfc
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic rst_n_s;
    logic mfc_s;

    // Reset asserts asynchronously (EN drops at once) but releases on a clock edge.
    mfc_sync #(.W(1)) u_rst_sync (
        .clk   (clk),
        .reset (reset),
        .d     (1'b1),
        .q     (rst_n_s)
    );

    mfc_sync #(.W(1)) u_mfc_sync (
        .clk   (clk),
        .reset (rst_n_s),
        .d     (mem_mfc),
        .q     (mfc_s)
    );

    state_e             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]  f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;
    logic               f_ack_q, f_ack_d;
    logic               d_ack_q, d_ack_d;
    logic               f_err_q, f_err_d;
    logic               d_err_q, d_err_d;
    logic               gnt;

    assign gnt = arb_pick(f_req, d_req, last_grant_q);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        mem_en_d     = 1'b0;
        mem_rw_d     = mem_rw_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        f_rdata_d    = f_rdata_q;
        d_rdata_d    = d_rdata_q;
        f_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        f_err_d      = 1'b0;
        d_err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (f_req || d_req) begin
                    grant_d      = gnt;
                    last_grant_d = gnt;
                    err_d        = 1'b0;
                    if (gnt == GNT_D) begin
                        mem_addr_d  = d_addr;
                        mem_rw_d    = d_rw;
                        mem_wdata_d = d_wdata;
                    end else begin
                        mem_addr_d  = f_addr;
                        mem_rw_d    = MEM_READ;
                        mem_wdata_d = '0;
                    end
                    state_d = SETUP;
                end
            end

            SETUP: begin
                mem_en_d = 1'b1;
                state_d  = ACCESS;
            end

            ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mfc_s) begin
                    // MEM keeps dataOut valid while MFC is high, so the raw bus is safe here.
                    if (mem_rw_q == MEM_READ) begin
                        if (grant_q == GNT_D) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            f_rdata_d = mem_rdata;
                        end
                    end
                    state_d = RELEASE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = RELEASE;
                end else begin
                    mem_en_d = 1'b1;
                end
            end

            RELEASE: begin
                if (!mfc_s) begin
                    f_ack_d = (grant_q == GNT_F);
                    d_ack_d = (grant_q == GNT_D);
                    f_err_d = (grant_q == GNT_F) && err_q;
                    d_err_d = (grant_q == GNT_D) && err_q;
                    state_d = DONE;
                end
            end

            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q      <= IDLE;
            grant_q      <= GNT_F;
            last_grant_q <= GNT_F;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_rw_q     <= MEM_READ;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            f_rdata_q    <= '0;
            d_rdata_q    <= '0;
            f_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            f_err_q      <= 1'b0;
            d_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            mem_en_q     <= mem_en_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            f_rdata_q    <= f_rdata_d;
            d_rdata_q    <= d_rdata_d;
            f_ack_q      <= f_ack_d;
            d_ack_q      <= d_ack_d;
            f_err_q      <= f_err_d;
            d_err_q      <= d_err_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign f_rdata   = f_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign f_ack     = f_ack_q;
    assign d_ack     = d_ack_q;
    assign f_err     = f_err_q;
    assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: behavioural MEM with jittered MFC, scoreboard of memory
// contents and expected grant order, plus per-cycle bus-protocol monitors.
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          f_req = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic [DW-1:0] f_rdata;
    logic          f_ack, f_err;
    logic          d_req = 1'b0;
    logic          d_rw = 1'b1;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ack, d_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = 16'hBAD0;
    logic          mem_rw, mem_en;
    logic          mem_mfc = 1'b0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_ack(f_ack), .f_err(f_err),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_rw(mem_rw), .mem_en(mem_en), .mem_mfc(mem_mfc)
    );

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] mem_arr [256];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] rd_lat;
    bit            mfc_dead = 1'b0;
    int            en_edges = 0;
    int            en_hi = 0;
    logic          rw_at_en = 1'b1;
    logic [DW-1:0] f_rd_exp = '0;
    logic [DW-1:0] d_rd_exp = '0;
    logic          last_g = GNT_F;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // MEM: acts on the EN rising edge, raises MFC after an unaligned delay, drops it after EN falls.
    always begin
        @(posedge mem_en);
        en_edges++;
        en_hi = 0;
        rw_at_en = mem_rw;
        if (mem_rw == MEM_WRITE) mem_arr[mem_addr[7:0]] = mem_wdata;
        rd_lat = mem_arr[mem_addr[7:0]];
        if (!mfc_dead) begin
            #($urandom_range(3, 47));
            if (mem_en) begin
                mem_rdata = rd_lat;
                mem_mfc = 1'b1;
            end
        end
        wait (!mem_en);
        #($urandom_range(1, 13));
        mem_mfc = 1'b0;
        mem_rdata = 16'hBAD0;
    end

    logic          prev_en = 1'b0;
    logic          prev_rw = 1'b1;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_wd = '0;

    always @(negedge clk) begin
        if (mem_en) en_hi++;
        if (reset) begin
            chk("ack_overlap", 32'(f_ack & d_ack), 32'(0));
            chk("err_without_ack", 32'((f_err & ~f_ack) | (d_err & ~d_ack)), 32'(0));
            chk("x_on_outputs", 32'($isunknown({f_rdata, f_ack, f_err, d_rdata, d_ack, d_err,
                                                mem_addr, mem_wdata, mem_rw, mem_en})), 32'(0));
            if (mem_en && prev_en)
                chk("bus_hold_during_en", {mem_addr, mem_wdata}, {prev_addr, prev_wd} | 32'(mem_rw ^ prev_rw));
        end
        prev_en   = mem_en;
        prev_rw   = mem_rw;
        prev_addr = mem_addr;
        prev_wd   = mem_wdata;
    end

    // nf/nd back-to-back accesses per requester, reqs held until their last ack.
    task automatic run_batch(input int nf, input int nd, input logic [AW-1:0] fa, input logic drw,
                             input logic [AW-1:0] da, input logic [DW-1:0] dw, input bit exp_err);
        logic exp_q[$];
        int   rf = nf;
        int   rd = nd;
        int   idx = 0;
        int   e0 = en_edges;
        int   budget;
        logic lg = last_g;
        while (rf > 0 || rd > 0) begin
            if (rf > 0 && rd > 0) lg = ~lg;
            else lg = (rd > 0) ? GNT_D : GNT_F;
            exp_q.push_back(lg);
            if (lg == GNT_D) rd--; else rf--;
        end
        last_g = lg;
        rf = nf;
        rd = nd;
        budget = (nf + nd) * (TO + 40);
        f_addr = fa; d_rw = drw; d_addr = da; d_wdata = dw;
        f_req = (nf > 0);
        d_req = (nd > 0);
        while ((rf > 0 || rd > 0) && budget > 0) begin
            @(negedge clk);
            budget--;
            if (f_ack) begin
                if (idx < exp_q.size()) chk("grant_order_f", 32'(GNT_F), 32'(exp_q[idx]));
                else chk("extra_ack_f", 32'(idx), 32'(exp_q.size()));
                chk("f_err", 32'(f_err), 32'(exp_err));
                chk("f_rw_at_en", 32'(rw_at_en), 32'(MEM_READ));
                if (!exp_err) f_rd_exp = ref_mem[fa[7:0]];
                chk("f_rdata", 32'(f_rdata), 32'(f_rd_exp));
                rf--; idx++;
                if (rf == 0) f_req = 1'b0;
            end
            if (d_ack) begin
                if (idx < exp_q.size()) chk("grant_order_d", 32'(GNT_D), 32'(exp_q[idx]));
                else chk("extra_ack_d", 32'(idx), 32'(exp_q.size()));
                chk("d_err", 32'(d_err), 32'(exp_err));
                chk("d_rw_at_en", 32'(rw_at_en), 32'(drw));
                if (!exp_err) begin
                    if (drw == MEM_READ) d_rd_exp = ref_mem[da[7:0]];
                    else ref_mem[da[7:0]] = dw;
                end else begin
                    chk("timeout_cycles", 32'(en_hi), 32'(TO));
                    chk("timeout_en_low", 32'(mem_en), 32'(0));
                end
                chk("d_rdata", 32'(d_rdata), 32'(d_rd_exp));
                rd--; idx++;
                if (rd == 0) d_req = 1'b0;
            end
        end
        chk("ack_wait_budget", 32'(rf + rd), 32'(0));
        f_req = 1'b0;
        d_req = 1'b0;
        chk("en_rising_edges", 32'(en_edges - e0), 32'(nf + nd));
        @(negedge clk);
        chk("ack_single_cycle", 32'({f_ack, d_ack}), 32'(0));
    endtask

    int nf, nd;

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 16'((i * 499) ^ 16'h5A5A);
        mem_arr[3] = 16'h7945;
        ref_mem = mem_arr;

        repeat (3) @(negedge clk);
        chk("rst_mem_en", 32'(mem_en), 32'(0));
        chk("rst_mem_rw", 32'(mem_rw), 32'(1));
        chk("rst_mem_addr", 32'(mem_addr), 32'(0));
        chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
        chk("rst_acks_errs", 32'({f_ack, d_ack, f_err, d_err}), 32'(0));
        chk("rst_rdata", {f_rdata, d_rdata}, 32'(0));
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // single fetch
        run_batch(1, 0, 16'h0003, MEM_READ, '0, '0, 1'b0);
        chk("t1_f_rdata", 32'(f_rdata), 32'h7945);

        // store then load same address
        run_batch(0, 1, '0, MEM_WRITE, 16'h0010, 16'hA5A5, 1'b0);
        run_batch(0, 1, '0, MEM_READ, 16'h0010, '0, 1'b0);
        chk("t2_d_rdata", 32'(d_rdata), 32'hA5A5);

        // both held for four accesses; a prior F access makes D win first
        run_batch(1, 0, 16'h0005, MEM_READ, '0, '0, 1'b0);
        run_batch(2, 2, 16'h0020, MEM_READ, 16'h0021, '0, 1'b0);

        // MEM never answers
        mfc_dead = 1'b1;
        run_batch(0, 1, '0, MEM_READ, 16'h0030, '0, 1'b1);
        mfc_dead = 1'b0;
        run_batch(1, 0, 16'h0031, MEM_READ, '0, '0, 1'b0);

        // reset during ACCESS
        f_addr = 16'h0007;
        f_req = 1'b1;
        for (int i = 0; i < 50 && !mem_en; i++) @(negedge clk);
        chk("t5_en_seen", 32'(mem_en), 32'(1));
        @(posedge clk);
        #3 reset = 1'b0;
        #1 chk("t5_en_async_drop", 32'(mem_en), 32'(0));
        last_g = GNT_F;
        f_rd_exp = '0;
        d_rd_exp = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t5_no_ack_in_reset", 32'({f_ack, d_ack}), 32'(0));
        end
        chk("t5_rdata_cleared", {f_rdata, d_rdata}, 32'(0));
        reset = 1'b1;
        run_batch(1, 0, 16'h0007, MEM_READ, '0, '0, 1'b0);

        // random mixes with jittered MFC and overlapping addresses
        for (int it = 0; it < 40; it++) begin
            nf = $urandom_range(0, 2);
            nd = $urandom_range(0, 2);
            if (nf + nd == 0) nf = 1;
            run_batch(nf, nd, 16'($urandom_range(64, 71)), 1'($urandom_range(0, 1)),
                      16'($urandom_range(64, 71)), 16'($urandom), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
